// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral with NUM_REGS write/readback registers.
// SPI pins are synchronised into clk; frames are {R/W, addr, data}, MSB first.
// A complete write frame commits one register one clk after chip-select rises;
// reads return the addressed register on cipo during the data phase.
module spi_regfile_peripheral #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         copi,
  input  logic                         ncs,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_pulse,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err,
  output logic                         addr_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic sclk_m, sclk_s, sclk_d;
  logic copi_m, copi_s;
  logic ncs_m, ncs_s, ncs_d;
  logic [1:0] vld_q;
  logic armed_q;

  logic [1:0]         state_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [FRAME_W-1:0] shift_q;
  logic [DATA_W-1:0]  tx_q;
  logic               read_q;
  logic [DATA_W-1:0]  regs [NUM_REGS];

  // Two-flop synchronisers plus history flops; idle values so reset never fakes an edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_m <= 1'b0; sclk_s <= 1'b0; sclk_d <= 1'b0;
      copi_m <= 1'b0; copi_s <= 1'b0;
      ncs_m  <= 1'b1; ncs_s  <= 1'b1; ncs_d  <= 1'b1;
      vld_q  <= 2'b00;
    end else begin
      sclk_m <= sclk; sclk_s <= sclk_m; sclk_d <= sclk_s;
      copi_m <= copi; copi_s <= copi_m;
      ncs_m  <= ncs;  ncs_s  <= ncs_m;  ncs_d  <= ncs_s;
      vld_q  <= {vld_q[0], 1'b1};
    end
  end

  logic sclk_rise, sclk_fall, ncs_rise;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;

  logic [FRAME_W-1:0] new_shift;
  assign new_shift = {shift_q[FRAME_W-2:0], copi_s};

  // Fields of the captured frame, valid during COMMIT.
  logic              c_rw;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;
  logic              commit, frame_ok, addr_ok;
  assign c_rw     = shift_q[FRAME_W-1];
  assign c_addr   = shift_q[FRAME_W-2 -: ADDR_W];
  assign c_data   = shift_q[DATA_W-1:0];
  assign commit   = (state_q == S_COMMIT);
  assign frame_ok = (bit_cnt_q == CNT_W'(FRAME_W));
  assign addr_ok  = (c_addr < ADDR_W'(NUM_REGS));

  assign wr_pulse  = commit & frame_ok & c_rw & addr_ok;
  assign addr_err  = commit & frame_ok & ~addr_ok;
  assign frame_err = commit & ~frame_ok;

  assign cipo_oe = read_q & ~ncs_s;
  assign cipo    = cipo_oe & tx_q[DATA_W-1];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end

  // Readback value for an address; out-of-range addresses read as zero.
  function automatic logic [DATA_W-1:0] reg_at(input logic [ADDR_W-1:0] a);
    reg_at = '0;
    for (int r = 0; r < NUM_REGS; r++)
      if (a == ADDR_W'(r)) reg_at = regs[r];
  endfunction

  // Frame FSM: arm on a genuine ncs high, shift on sclk, commit one clk after ncs rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      read_q    <= 1'b0;
      armed_q   <= 1'b0;
      wr_addr   <= '0;
      // NOTE: the register file is small and must read zero after reset, so every entry is reset.
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      // ncs counts as seen high only once the synchroniser holds real pin values.
      if (vld_q[1] && ncs_s) armed_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          read_q <= 1'b0;
          if (armed_q && !ncs_s) begin
            state_q   <= S_SHIFT;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            armed_q   <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (ncs_rise) begin
            state_q <= S_COMMIT;
            read_q  <= 1'b0;
          end else begin
            if (sclk_rise) begin
              if (bit_cnt_q < CNT_W'(FRAME_W)) begin
                shift_q   <= new_shift;
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (bit_cnt_q == CNT_W'(ADDR_W)) begin
                  tx_q   <= reg_at(new_shift[ADDR_W-1:0]);
                  read_q <= ~new_shift[ADDR_W];
                end
                if (bit_cnt_q == CNT_W'(FRAME_W - 1)) read_q <= 1'b0;
              end else begin
                bit_cnt_q <= CNT_W'(FRAME_W + 1);
              end
            end
            // The MSB stays on cipo until the host has sampled the first data bit.
            if (sclk_fall && read_q && (bit_cnt_q > CNT_W'(ADDR_W + 1)))
              tx_q <= {tx_q[DATA_W-2:0], 1'b0};
          end
        end
        S_COMMIT: begin
          state_q <= S_IDLE;
          if (wr_pulse) begin
            wr_addr <= c_addr;
            for (int r = 0; r < NUM_REGS; r++)
              if (c_addr == ADDR_W'(r)) regs[r] <= c_data;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench for spi_regfile_peripheral: a table of SPI frames with
// hand-computed register images, pulse counts and readback data, plus
// hand-written sequences for short ncs gaps and reset in mid-frame.
module tb_spi_regfile_peripheral;

  localparam int NUM_REGS = 5;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int HALF     = 8;  // clks per sclk half period

  logic clk = 1'b0;
  logic rst, sclk, copi, ncs;
  logic cipo, cipo_oe, wr_pulse, frame_err, addr_err;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic [ADDR_W-1:0] wr_addr;

  spi_regfile_peripheral #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs_flat(regs_flat),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr),
    .frame_err(frame_err), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0, ferr_cnt = 0, aerr_cnt = 0;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_pulse)  wr_cnt++;
    if (frame_err) ferr_cnt++;
    if (addr_err)  aerr_cnt++;
  end

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    logic [39:0] regs;
    int          wr;
    int          ferr;
    int          aerr;
    logic [7:0]  rd;
    int          oe;
    logic [6:0]  wa;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI bit: present copi with sclk low, sample cipo just before the rising edge.
  task automatic spi_bit(input logic b, output logic c, output logic oe);
    copi = b;
    sclk = 1'b0;
    wait_clk(HALF);
    c  = cipo;
    oe = cipo_oe;
    sclk = 1'b1;
    wait_clk(HALF);
    sclk = 1'b0;
  endtask

  // Full frame; rd collects cipo before rises 8..15, oe counts samples with cipo_oe high.
  task automatic spi_frame(input logic [31:0] bits, input int nbits, input int gap,
                           output logic [7:0] rd, output int oe);
    logic c, o;
    rd = '0;
    oe = 0;
    ncs = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(bits[nbits-1-i], c, o);
      if (o) oe++;
      if (i >= 8 && i < 16) rd = {rd[6:0], c};
    end
    wait_clk(HALF);
    ncs = 1'b1;
    wait_clk(gap);
  endtask

  initial begin
    logic [7:0] rd;
    int oe, w0, f0, a0;
    logic c, o;

    vecs[0]  = '{32'h8155,  16, 40'h00_00_00_55_00, 1, 0, 0, 8'h00, 0, 7'd1};
    vecs[1]  = '{32'h84A5,  16, 40'hA5_00_00_55_00, 1, 0, 0, 8'h00, 0, 7'd4};
    vecs[2]  = '{32'h0400,  16, 40'hA5_00_00_55_00, 0, 0, 0, 8'hA5, 8, 7'd4};
    vecs[3]  = '{32'h0155,  16, 40'hA5_00_00_55_00, 0, 0, 0, 8'h55, 8, 7'd4};
    vecs[4]  = '{32'h8A12,  16, 40'hA5_00_00_55_00, 0, 0, 1, 8'h00, 0, 7'd4};
    vecs[5]  = '{32'h8512,  16, 40'hA5_00_00_55_00, 0, 0, 1, 8'h00, 0, 7'd4};
    vecs[6]  = '{32'h0500,  16, 40'hA5_00_00_55_00, 0, 0, 1, 8'h00, 8, 7'd4};
    vecs[7]  = '{32'h4019,  15, 40'hA5_00_00_55_00, 0, 1, 0, 8'h00, 0, 7'd4};
    vecs[8]  = '{32'h10067, 17, 40'hA5_00_00_55_00, 0, 1, 0, 8'h00, 0, 7'd4};
    vecs[9]  = '{32'h0,      0, 40'hA5_00_00_55_00, 0, 1, 0, 8'h00, 0, 7'd4};
    vecs[10] = '{32'h8001,  16, 40'hA5_00_00_55_01, 1, 0, 0, 8'h00, 0, 7'd0};
    vecs[11] = '{32'h82FF,  16, 40'hA5_00_FF_55_01, 1, 0, 0, 8'h00, 0, 7'd2};
    vecs[12] = '{32'h8380,  16, 40'hA5_80_FF_55_01, 1, 0, 0, 8'h00, 0, 7'd3};
    vecs[13] = '{32'h0380,  16, 40'hA5_80_FF_55_01, 0, 0, 0, 8'h80, 8, 7'd3};

    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);

    check("reset regs",    64'(regs_flat), 64'h0);
    check("reset wr_addr", 64'(wr_addr),   64'h0);
    check("reset cipo",    64'(cipo),      64'h0);
    check("reset cipo_oe", 64'(cipo_oe),   64'h0);
    check("reset pulses",  64'(wr_cnt + ferr_cnt + aerr_cnt), 64'h0);

    for (int i = 0; i < 14; i++) begin
      w0 = wr_cnt; f0 = ferr_cnt; a0 = aerr_cnt;
      spi_frame(vecs[i].bits, vecs[i].nbits, 8, rd, oe);
      check($sformatf("v%0d regs", i),      64'(regs_flat),     64'(vecs[i].regs));
      check($sformatf("v%0d wr_pulse", i),  64'(wr_cnt - w0),   64'(vecs[i].wr));
      check($sformatf("v%0d frame_err", i), 64'(ferr_cnt - f0), 64'(vecs[i].ferr));
      check($sformatf("v%0d addr_err", i),  64'(aerr_cnt - a0), 64'(vecs[i].aerr));
      check($sformatf("v%0d wr_addr", i),   64'(wr_addr),       64'(vecs[i].wa));
      check($sformatf("v%0d cipo data", i), 64'(rd),            64'(vecs[i].rd));
      check($sformatf("v%0d cipo_oe", i),   64'(oe),            64'(vecs[i].oe));
    end

    // ncs high for a single clk between two writes: both must commit in order.
    w0 = wr_cnt;
    spi_frame(32'h823C, 16, 1, rd, oe);
    spi_frame(32'h835A, 16, 8, rd, oe);
    check("short gap regs",     64'(regs_flat),   64'hA5_5A_3C_55_01);
    check("short gap wr_pulse", 64'(wr_cnt - w0), 64'd2);
    check("short gap wr_addr",  64'(wr_addr),     64'd3);

    // Reset after 9 bits, released with ncs low; the rest of that frame is ignored.
    w0 = wr_cnt; f0 = ferr_cnt; a0 = aerr_cnt;
    ncs = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 9; i++) spi_bit(1'(32'h8177 >> (15 - i)), c, o);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    for (int i = 9; i < 16; i++) spi_bit(1'(32'h8177 >> (15 - i)), c, o);
    wait_clk(HALF);
    ncs = 1'b1;
    wait_clk(8);
    check("cut frame regs",    64'(regs_flat),     64'h0);
    check("cut frame wr_addr", 64'(wr_addr),       64'h0);
    check("cut frame pulses",  64'((wr_cnt - w0) + (ferr_cnt - f0) + (aerr_cnt - a0)), 64'h0);

    w0 = wr_cnt;
    spi_frame(32'h8177, 16, 8, rd, oe);
    check("after reset regs",     64'(regs_flat),   64'h00_00_00_77_00);
    check("after reset wr_pulse", 64'(wr_cnt - w0), 64'd1);
    check("after reset wr_addr",  64'(wr_addr),     64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
